sq_period_meter: RTL and testbench
==================================

Name: sq_period_meter

Overview:
- Receive-side counterpart of the divided-clock square-wave generator.
- Samples an asynchronous square wave, e.g. the 1 MHz divided output fed back from a 50 MHz clk.
- Measures high time, low time and period in clk cycles.
- Flags lock when both phases match an expected half-period, and flags loss of signal on timeout.
- Sits in the scan-control clocking path as a health monitor for generated and external scan clocks.

Parameters:
- CNT_W, 16: width of phase counters; TIMEOUT must be < 2^CNT_W.
- EXP_HALF, 25: expected half-period in clk cycles.
- TOL, 1: allowed absolute deviation per phase, in cycles.
- LOCK_N, 4: consecutive matching periods required for lock.
- TIMEOUT, 1024: cycles without an edge before no_signal is raised.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- sq_in  in  1  square wave, asynchronous to clk.
- hi_cnt  out  CNT_W  last complete high-phase length, in cycles.
- lo_cnt  out  CNT_W  last complete low-phase length, in cycles.
- period  out  CNT_W+1  hi_cnt + lo_cnt of the last full period.
- meas_valid  out  1  one-cycle pulse when hi_cnt/lo_cnt/period update as a full set.
- locked  out  1  LOCK_N consecutive in-tolerance periods seen.
- no_signal  out  1  no edge for TIMEOUT cycles, or none since reset.

Behaviour:
- Reset (async, active-high): all flops clear, including the synchronizer.
  - Outputs: hi_cnt=0, lo_cnt=0, period=0, meas_valid=0, locked=0, no_signal=1.
  - State = WAIT.
- Sync: sq_in passes through 2 flops (s1, s2), then a delay flop d.
  - edge = s2 != d; rise = s2 & ~d; fall = ~s2 & d.
  - Latency from sq_in transition to edge is 2-3 clk cycles.
- run_cnt (CNT_W bits):
  - On edge, run_cnt <= 1; otherwise run_cnt <= run_cnt+1, saturating at all-ones.
  - At an edge, the current run_cnt equals the length of the phase just ended (a 25-cycle phase gives 25).
- States:
  - WAIT (after reset or timeout): the first edge moves to ARMED; the partial phase is discarded; no_signal <= 0.
  - ARMED and RUN:
    - fall: hi_cnt <= run_cnt; hi_ok <= 1; state RUN.
    - rise: lo_cnt <= run_cnt; state RUN.
    - If hi_ok=1 at a rise: period <= hi_cnt + run_cnt (zero-extended); meas_valid <= 1.
- meas_valid:
  - Asserted the cycle after the rising-edge detect, coincident with the updated lo_cnt and period. Held 1 cycle.
  - When the first edge after WAIT is a fall, the first rise yields lo_cnt only, with no meas_valid. The first meas_valid comes at the following rise.
  - When the first edge after WAIT is a rise, the first meas_valid comes at the second rise.
- Lock:
  - Evaluated on every meas_valid event, using the new hi and lo values.
  - match = |hi-EXP_HALF|<=TOL and |lo-EXP_HALF|<=TOL, computed without unsigned wrap.
  - On match: match_cnt++, saturating at LOCK_N. locked <= 1 in the same cycle match_cnt reaches LOCK_N, coincident with that meas_valid.
  - On mismatch: match_cnt <= 0 and locked <= 0, coincident with meas_valid.
- Timeout:
  - Condition: in ARMED or RUN with no edge this cycle and run_cnt == TIMEOUT.
  - Effect next cycle: no_signal=1, locked=0, match_cnt=0, hi_ok=0, state=WAIT.
  - hi_cnt, lo_cnt and period hold their last values.
- Edge on the same cycle run_cnt==TIMEOUT: the edge wins and no timeout occurs.
- Saturated run_cnt is captured as-is. This is only reachable when TIMEOUT is misconfigured.
- period adds one extra bit, so it never overflows.

Decomposition:
- Package sq_meter_pkg holds:
  - default constants EXP_HALF_DEF, TOL_DEF, LOCK_N_DEF, TIMEOUT_DEF;
  - state encoding WAIT/ARMED/RUN.
- Sub-module sq_edge_sync: 2-flop synchronizer, delay flop and rise/fall outputs, with async rst. Reused by other async-input monitors.

Test Plan:
- Reset, then drive 25-high/25-low cycles aligned to clk, starting low -> first meas_valid at the second rise with hi_cnt=25, lo_cnt=25, period=50. locked=1 on the 4th meas_valid.
- Duty 30/20 -> hi_cnt=30, lo_cnt=20, period=50 on every meas_valid. locked stays 0 and no_signal=0.
- Lock at 26/24, then one 28/22 period, then 25/25 -> locked drops on the 28/22 meas_valid. It re-asserts after 4 further good periods.
- After lock, hold sq_in high -> no_signal=1 and locked=0 once 1024 cycles pass since the last edge. Resume toggling: no_signal clears at the first edge, and no meas_valid occurs until a full hi+lo has been measured.
- First edge after reset is a fall (sq_in starts high) -> no meas_valid at the first rise (lo_cnt updates only). meas_valid at the next rise with correct hi and lo.
- Assert rst asynchronously mid-phase while locked -> all outputs go to reset values before the next clk edge, no_signal=1. Measurement restarts cleanly after release.

Source files
------------

// File: rtl/sq_meter_pkg.sv
// sq_meter_pkg: shared constants, state encoding and a tolerance helper for
// the square-wave period meter.
package sq_meter_pkg;

  localparam int unsigned EXP_HALF_DEF = 25;
  localparam int unsigned TOL_DEF      = 1;
  localparam int unsigned LOCK_N_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF  = 1024;

  typedef enum logic [1:0] {
    WAIT  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } state_e;

  // |v - exp_v| <= tol, evaluated in 34 bits so neither side can wrap.
  function automatic logic in_tol(input logic [31:0] v,
                                  input int unsigned exp_v,
                                  input int unsigned tol);
    logic [33:0] vv, ev, tv;
    vv = {2'b00, v};
    ev = {2'b00, exp_v};
    tv = {2'b00, tol};
    return (vv + tv >= ev) && (vv <= ev + tv);
  endfunction

endpackage

// File: rtl/sq_edge_sync.sv
// sq_edge_sync: brings an asynchronous level into the clk domain through two
// flops, then a delay flop for edge detection.
//   clk, rst  : clock, async active-high reset (all flops clear to 0)
//   async_in  : asynchronous input level
//   edge_det  : synchronized level changed this cycle
//   rise/fall : direction of that change
module sq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_det,
  output logic rise,
  output logic fall
);

  logic s1, s2, d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      d  <= s2;
    end
  end

  assign edge_det = s2 ^ d;
  assign rise     = s2 & ~d;
  assign fall     = ~s2 & d;

endmodule

// File: rtl/sq_period_meter.sv
// sq_period_meter: measures high time, low time and period of an asynchronous
// square wave in clk cycles, declares lock after LOCK_N consecutive periods
// within TOL of EXP_HALF per phase, and flags loss of signal after TIMEOUT
// cycles without an edge.
//   clk, rst   : clock, async active-high reset
//   sq_in      : square wave, asynchronous to clk
//   hi_cnt     : last complete high-phase length
//   lo_cnt     : last complete low-phase length
//   period     : hi_cnt + lo_cnt of the last full period (one extra bit)
//   meas_valid : one-cycle pulse when lo_cnt/period update as a full set
//   locked     : LOCK_N consecutive in-tolerance periods seen
//   no_signal  : no edge for TIMEOUT cycles, or none since reset
import sq_meter_pkg::*;

module sq_period_meter #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned EXP_HALF = EXP_HALF_DEF,
  parameter int unsigned TOL      = TOL_DEF,
  parameter int unsigned LOCK_N   = LOCK_N_DEF,
  parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sq_in,
  output logic [CNT_W-1:0] hi_cnt,
  output logic [CNT_W-1:0] lo_cnt,
  output logic [CNT_W:0]   period,
  output logic             meas_valid,
  output logic             locked,
  output logic             no_signal
);

  localparam int unsigned MC_W = $clog2(LOCK_N + 1);

  logic             edge_det, rise, fall;
  logic [CNT_W-1:0] run_cnt;
  logic [MC_W-1:0]  match_cnt;
  logic             hi_ok;
  logic             tmo;
  logic             match;
  state_e           state, state_nxt;

  sq_edge_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sq_in),
    .edge_det (edge_det),
    .rise     (rise),
    .fall     (fall)
  );

  // Length of the phase in progress; at an edge it holds the length of the
  // phase that just ended.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 run_cnt <= '0;
    else if (edge_det)       run_cnt <= CNT_W'(1);
    else if (run_cnt != '1)  run_cnt <= run_cnt + 1'b1;
  end

  // An edge landing on the timeout cycle takes priority.
  assign tmo   = (state != WAIT) && !edge_det && (run_cnt == CNT_W'(TIMEOUT));
  // At a rise, hi_cnt holds the high phase and run_cnt the low phase.
  assign match = in_tol(32'(hi_cnt), EXP_HALF, TOL) &&
                 in_tol(32'(run_cnt), EXP_HALF, TOL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WAIT:       if (edge_det) state_nxt = ARMED;
      ARMED, RUN: begin
        if (tmo)           state_nxt = WAIT;
        else if (edge_det) state_nxt = RUN;
      end
      default:    state_nxt = WAIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_cnt     <= '0;
      lo_cnt     <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      no_signal  <= 1'b1;
      match_cnt  <= '0;
      hi_ok      <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (tmo) begin
        // Measurements hold their last values; only status is dropped.
        no_signal <= 1'b1;
        locked    <= 1'b0;
        match_cnt <= '0;
        hi_ok     <= 1'b0;
      end else if (state == WAIT) begin
        // First edge only re-arms; the partial phase before it is discarded.
        if (edge_det) no_signal <= 1'b0;
      end else begin
        if (fall) begin
          hi_cnt <= run_cnt;
          hi_ok  <= 1'b1;
        end
        if (rise) begin
          lo_cnt <= run_cnt;
          // A period is only complete once a high phase has been captured.
          if (hi_ok) begin
            period     <= {1'b0, hi_cnt} + {1'b0, run_cnt};
            meas_valid <= 1'b1;
            if (match) begin
              if (match_cnt < MC_W'(LOCK_N)) match_cnt <= match_cnt + 1'b1;
              locked <= (match_cnt >= MC_W'(LOCK_N - 1));
            end else begin
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sq_period_meter.sv
// Scoreboard bench for sq_period_meter: the stimulus pushes the hand-computed
// result of each full period, the monitor pops one entry per meas_valid.
module tb_sq_period_meter;
  import sq_meter_pkg::*;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sq_in = 1'b0;
  logic [CNT_W-1:0] hi_cnt, lo_cnt;
  logic [CNT_W:0]   period;
  logic             meas_valid, locked, no_signal;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int hi;
    int lo;
    int per;
    int lk;
  } exp_t;
  exp_t q[$];

  sq_period_meter #(
    .CNT_W(CNT_W), .EXP_HALF(25), .TOL(1), .LOCK_N(4), .TIMEOUT(1024)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sq_in      (sq_in),
    .hi_cnt     (hi_cnt),
    .lo_cnt     (lo_cnt),
    .period     (period),
    .meas_valid (meas_valid),
    .locked     (locked),
    .no_signal  (no_signal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every meas_valid must match the oldest expected period.
  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_meas_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("meas_hi_cnt", int'(hi_cnt), e.hi);
        chk("meas_lo_cnt", int'(lo_cnt), e.lo);
        chk("meas_period", int'(period), e.per);
        chk("meas_locked", int'(locked), e.lk);
      end
    end
  end

  // Callers sit on a negedge; the level is held for len cycles.
  task automatic drive_phase(input logic lvl, input int len);
    sq_in = lvl;
    repeat (len) @(negedge clk);
  endtask

  // High then low; the result appears at the rise that follows.
  task automatic cyc(input int hi, input int lo, input int lk);
    exp_t e;
    drive_phase(1'b1, hi);
    drive_phase(1'b0, lo);
    e.hi = hi; e.lo = lo; e.per = hi + lo; e.lk = lk;
    q.push_back(e);
  endtask

  task automatic do_reset(input logic lvl);
    rst   = 1'b1;
    sq_in = lvl;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hi_cnt"},     int'(hi_cnt), 0);
    chk({tag, "_lo_cnt"},     int'(lo_cnt), 0);
    chk({tag, "_period"},     int'(period), 0);
    chk({tag, "_meas_valid"}, int'(meas_valid), 0);
    chk({tag, "_locked"},     int'(locked), 0);
    chk({tag, "_no_signal"},  int'(no_signal), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state, then nominal 25/25 starting low: lock on 4th measurement.
    do_reset(1'b0);
    chk_reset_vals("reset");
    drive_phase(1'b0, 10);
    cyc(25, 25, 0);
    cyc(25, 25, 0);
    cyc(25, 25, 0);
    cyc(25, 25, 1);
    cyc(25, 25, 1);
    drive_phase(1'b1, 5);
    chk("nominal_no_signal", int'(no_signal), 0);

    // 30/20 duty: correct period, never locks.
    do_reset(1'b0);
    drive_phase(1'b0, 5);
    repeat (5) cyc(30, 20, 0);
    drive_phase(1'b1, 5);
    chk("duty_locked", int'(locked), 0);
    chk("duty_no_signal", int'(no_signal), 0);

    // 26/24 sits on the tolerance edge and locks; 28/22 breaks lock.
    do_reset(1'b0);
    drive_phase(1'b0, 5);
    cyc(26, 24, 0);
    cyc(26, 24, 0);
    cyc(26, 24, 0);
    cyc(26, 24, 1);
    cyc(28, 22, 0);
    cyc(25, 25, 0);
    cyc(25, 25, 0);
    cyc(25, 25, 0);
    cyc(25, 25, 1);

    // Hold high: timeout about 1027 cycles after the drive.
    drive_phase(1'b1, 1015);
    chk("pre_timeout_no_signal", int'(no_signal), 0);
    chk("pre_timeout_locked", int'(locked), 1);
    repeat (25) @(negedge clk);
    chk("timeout_no_signal", int'(no_signal), 1);
    chk("timeout_locked", int'(locked), 0);
    chk("timeout_hi_hold", int'(hi_cnt), 25);
    chk("timeout_period_hold", int'(period), 50);

    // Resume: fall is the first edge, the next rise gives lo_cnt only.
    sq_in = 1'b0;
    repeat (5) @(negedge clk);
    chk("resume_no_signal", int'(no_signal), 0);
    repeat (17) @(negedge clk);
    sq_in = 1'b1;
    repeat (6) @(negedge clk);
    chk("resume_lo_only", int'(lo_cnt), 22);
    repeat (21) @(negedge clk);
    drive_phase(1'b0, 23);
    begin
      exp_t e;
      e.hi = 27; e.lo = 23; e.per = 50; e.lk = 0;
      q.push_back(e);
    end
    drive_phase(1'b1, 5);

    // High during reset: the cleared synchronizer sees that level as a rise,
    // which is the discarded first edge, so the high phase after release is
    // measured in full and the first rise completes a period.
    do_reset(1'b1);
    repeat (24) @(negedge clk);
    drive_phase(1'b0, 26);
    begin
      exp_t e;
      e.hi = 24; e.lo = 26; e.per = 50; e.lk = 0;
      q.push_back(e);
    end
    cyc(25, 25, 0);
    drive_phase(1'b1, 5);

    // Async reset mid-phase while locked.
    do_reset(1'b0);
    drive_phase(1'b0, 5);
    repeat (3) cyc(25, 25, 0);
    cyc(25, 25, 1);
    drive_phase(1'b1, 10);
    chk("pre_async_locked", int'(locked), 1);
    #2 rst = 1'b1;
    #1 chk_reset_vals("async_rst");
    sq_in = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_phase(1'b0, 10);
    cyc(24, 26, 0);
    cyc(25, 25, 0);
    drive_phase(1'b1, 5);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
